// File: rtl/elevator_sched_fsm.sv
// Elevator motion/door scheduler: owns cabin position, direction mode, travel and door timers.
// Latency: all outputs registered; IDLE acts on requests one cycle after they are seen.
// Backpressure: none; requests stay latched upstream until arrive_o clears them.
module elevator_sched_fsm #(
    parameter int FLOORS       = 4,
    parameter int TRAVEL_TICKS = 64,
    parameter int DOOR_TICKS   = 21,
    parameter int CLOSE_SKIP   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic [FLOORS-1:0] up_req_i,
    input  logic [FLOORS-1:0] down_req_i,
    input  logic [FLOORS-1:0] in_req_i,
    input  logic              door_hold_i,
    input  logic              door_close_i,
    output logic [FLOORS-1:0] position_o,
    output logic [1:0]        ud_mode_o,
    output logic              moving_o,
    output logic              door_open_o,
    output logic [1:0]        door_stage_o,
    output logic              arrive_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_CHECK,
        S_DOOR,
        S_DONE
    } state_t;

    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS);
    localparam logic [DW-1:0] DOOR_M1     = DW'(DOOR_TICKS - 1);
    localparam logic [DW-1:0] DOOR_M2     = DW'(DOOR_TICKS - 2);
    localparam logic [DW-1:0] DOOR_SKIP   = DW'(DOOR_TICKS - CLOSE_SKIP);

    localparam logic [1:0] UD_IDLE = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DN   = 2'b10;

    state_t            state_q;
    logic [FLOORS-1:0] pos_q;
    logic [1:0]        ud_q;
    logic              moving_q;
    logic              door_open_q;
    logic              arrive_q;
    logic [1:0]        door_stage_q;
    logic [1:0]        door_stage_d;
    logic [TW-1:0]     travel_cnt_q;
    logic [DW-1:0]     door_cnt_q;
    logic [DW-1:0]     door_cnt_d;
    logic              door_done;

    logic [FLOORS-1:0] all_req;
    logic [FLOORS-1:0] below_mask;
    logic [FLOORS-1:0] above_mask;
    logic              above;
    logic              below;
    logic              here_req;
    logic              check_stop;

    // pos_q is one-hot, so pos-1 is exactly the set of floors beneath the cabin
    always_comb begin
        all_req    = up_req_i | down_req_i | in_req_i;
        below_mask = pos_q - FLOORS'(1);
        above_mask = ~(below_mask | pos_q);
        above      = |(all_req & above_mask);
        below      = |(all_req & below_mask);
        here_req   = |(all_req & pos_q);
        check_stop = 1'b0;
        if (ud_q == UD_DN) begin
            check_stop = (|((down_req_i | in_req_i) & pos_q)) || !below || pos_q[0];
        end else begin
            check_stop = (|((up_req_i | in_req_i) & pos_q)) || !above || pos_q[FLOORS-1];
        end
    end

    // Hold beats close; the count is parked at zero whenever the door is not cycling
    always_comb begin
        door_cnt_d = door_cnt_q;
        door_done  = 1'b0;
        if (state_q != S_DOOR) begin
            door_cnt_d = '0;
        end else if (tick_i) begin
            if (door_cnt_q == DOOR_LAST) begin
                door_cnt_d = '0;
                door_done  = 1'b1;
            end else if (!door_hold_i) begin
                if (door_close_i && (door_cnt_q < DOOR_SKIP)) begin
                    door_cnt_d = DOOR_SKIP;
                end else begin
                    door_cnt_d = door_cnt_q + DW'(1);
                end
            end
        end
    end

    always_comb begin
        door_stage_d = 2'd3;
        if ((door_cnt_d == '0) || (door_cnt_d == DOOR_LAST)) begin
            door_stage_d = 2'd0;
        end else if ((door_cnt_d == DW'(1)) || (door_cnt_d == DOOR_M1)) begin
            door_stage_d = 2'd1;
        end else if ((door_cnt_d == DW'(2)) || (door_cnt_d == DOOR_M2)) begin
            door_stage_d = 2'd2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pos_q        <= FLOORS'(1);
            ud_q         <= UD_IDLE;
            moving_q     <= 1'b0;
            door_open_q  <= 1'b0;
            door_stage_q <= 2'd0;
            arrive_q     <= 1'b0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
        end else begin
            arrive_q     <= 1'b0;
            door_cnt_q   <= door_cnt_d;
            door_stage_q <= door_stage_d;
            case (state_q)
                S_IDLE: begin
                    if (here_req) begin
                        state_q     <= S_DOOR;
                        arrive_q    <= 1'b1;
                        door_open_q <= 1'b1;
                    end else if (above) begin
                        state_q  <= S_MOVE;
                        ud_q     <= UD_UP;
                        moving_q <= 1'b1;
                    end else if (below) begin
                        state_q  <= S_MOVE;
                        ud_q     <= UD_DN;
                        moving_q <= 1'b1;
                    end else begin
                        ud_q <= UD_IDLE;
                    end
                end
                S_MOVE: begin
                    if (tick_i) begin
                        if (travel_cnt_q == TRAVEL_LAST) begin
                            travel_cnt_q <= '0;
                            state_q      <= S_CHECK;
                            if ((ud_q == UD_UP) && !pos_q[FLOORS-1]) begin
                                pos_q <= pos_q << 1;
                            end else if ((ud_q == UD_DN) && !pos_q[0]) begin
                                pos_q <= pos_q >> 1;
                            end
                        end else begin
                            travel_cnt_q <= travel_cnt_q + TW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (check_stop) begin
                        state_q     <= S_DOOR;
                        moving_q    <= 1'b0;
                        door_open_q <= 1'b1;
                        arrive_q    <= 1'b1;
                    end else begin
                        state_q <= S_MOVE;
                    end
                end
                S_DOOR: begin
                    if (door_done) begin
                        state_q     <= S_DONE;
                        door_open_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Keep sweeping in the current direction; otherwise let IDLE re-decide
                    if ((ud_q == UD_UP) && above) begin
                        state_q  <= S_MOVE;
                        moving_q <= 1'b1;
                    end else if ((ud_q == UD_DN) && below) begin
                        state_q  <= S_MOVE;
                        moving_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ud_q    <= UD_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign position_o   = pos_q;
    assign ud_mode_o    = ud_q;
    assign moving_o     = moving_q;
    assign door_open_o  = door_open_q;
    assign door_stage_o = door_stage_q;
    assign arrive_o     = arrive_q;

endmodule

// File: tb/tb_elevator_sched_fsm.sv
// Scoreboard bench for elevator_sched_fsm: stimulus queues expected output events with cycle offsets,
// a negedge monitor turns observed output changes into events and compares them in order.
module tb_elevator_sched_fsm;

    localparam int EV_UD   = 0;
    localparam int EV_POS  = 1;
    localparam int EV_ARR  = 2;
    localparam int EV_STG  = 3;
    localparam int EV_DEND = 4;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] val;
        int         rel;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] up_req = 4'b0;
    logic [3:0] down_req = 4'b0;
    logic [3:0] in_req = 4'b0;
    logic       door_hold = 1'b0;
    logic       door_close = 1'b0;

    logic [3:0] position;
    logic [1:0] ud_mode;
    logic       moving;
    logic       door_open;
    logic [1:0] door_stage;
    logic       arrive;

    ev_t         evq[$];
    logic [10:0] snapq[$];
    string       snaptagq[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int t0 = 0;
    bit mute = 1'b1;

    logic [3:0]  prev_pos;
    logic [1:0]  prev_ud;
    logic [1:0]  prev_stage;
    logic        prev_open;
    logic [10:0] snap_got;
    logic [10:0] snap_want;
    string       snap_tag;

    elevator_sched_fsm dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick),
        .up_req_i     (up_req),
        .down_req_i   (down_req),
        .in_req_i     (in_req),
        .door_hold_i  (door_hold),
        .door_close_i (door_close),
        .position_o   (position),
        .ud_mode_o    (ud_mode),
        .moving_o     (moving),
        .door_open_o  (door_open),
        .door_stage_o (door_stage),
        .arrive_o     (arrive)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic note(input int kind, input logic [7:0] val);
        ev_t e;
        int  rel;
        rel = cyc - t0;
        checks++;
        if (evq.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d val=%h rel=%0d, want no event", kind, val, rel);
        end else begin
            e = evq.pop_front();
            if (e.kind == kind && e.val === val && e.rel == rel) begin
                passes++;
            end else begin
                $display("FAIL %s: got kind=%0d val=%h rel=%0d, want kind=%0d val=%h rel=%0d",
                         e.tag, kind, val, rel, e.kind, e.val, e.rel);
            end
        end
    endtask

    // Monitor: snapshots first, then output-change events in a fixed per-cycle order
    initial begin
        forever begin
            @(negedge clk);
            if (snapq.size() > 0) begin
                snap_want = snapq.pop_front();
                snap_tag  = snaptagq.pop_front();
                snap_got  = {position, ud_mode, moving, door_open, door_stage, arrive};
                checks++;
                if (snap_got === snap_want) passes++;
                else $display("FAIL %s: got %b, want %b", snap_tag, snap_got, snap_want);
            end
            if (!mute) begin
                if (ud_mode !== prev_ud) note(EV_UD, {6'd0, ud_mode});
                if (position !== prev_pos) note(EV_POS, {4'd0, position});
                if (arrive === 1'b1) note(EV_ARR, {2'd0, ud_mode, position});
                if (door_stage !== prev_stage) note(EV_STG, {6'd0, door_stage});
                if (prev_open === 1'b1 && door_open === 1'b0) note(EV_DEND, {4'd0, position});
            end
            prev_ud    = ud_mode;
            prev_pos   = position;
            prev_stage = door_stage;
            prev_open  = door_open;
        end
    end

    // Stands in for the request processor: served floor's requests drop after arrive
    task automatic step();
        @(posedge clk);
        #1;
        if (arrive === 1'b1) begin
            up_req   = up_req & ~position;
            down_req = down_req & ~position;
            in_req   = in_req & ~position;
        end
    endtask

    task automatic start();
        t0 = cyc;
    endtask

    task automatic wait_until(input int rel);
        while (cyc - t0 < rel) step();
    endtask

    task automatic ev(input string tag, input int kind, input logic [7:0] val, input int rel);
        ev_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        e.rel  = rel;
        evq.push_back(e);
    endtask

    task automatic snap(input string tag, input logic [10:0] want);
        snapq.push_back(want);
        snaptagq.push_back(tag);
    endtask

    // Plain door cycle that opened at offset a, stretched by ext frozen ticks
    task automatic exp_door(input string tag, input int a, input int ext, input logic [3:0] pos);
        ev({tag, "_stg1"},  EV_STG,  8'd1, a + 1);
        ev({tag, "_stg2"},  EV_STG,  8'd2, a + 2);
        ev({tag, "_stg3"},  EV_STG,  8'd3, a + 3);
        ev({tag, "_stg2b"}, EV_STG,  8'd2, a + 19 + ext);
        ev({tag, "_stg1b"}, EV_STG,  8'd1, a + 20 + ext);
        ev({tag, "_stg0"},  EV_STG,  8'd0, a + 21 + ext);
        ev({tag, "_dend"},  EV_DEND, {4'd0, pos}, a + 22 + ext);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((evq.size() > 0 || snapq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (evq.size() > 0) begin
            checks++;
            $display("FAIL %s_timeout: got %0d events pending after %0d cycles, want 0",
                     tag, evq.size(), budget);
            evq.delete();
        end
    endtask

    task automatic do_reset(input string tag);
        mute       = 1'b1;
        rst        = 1'b1;
        up_req     = 4'b0;
        down_req   = 4'b0;
        in_req     = 4'b0;
        door_hold  = 1'b0;
        door_close = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        snap(tag, {4'b0001, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0});
        step();
        mute = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // T1: single cabin call two floors up
        do_reset("t1_reset");
        in_req = 4'b0100;
        start();
        ev("t1_up",   EV_UD,  8'h01, 1);
        ev("t1_f2",   EV_POS, 8'h02, 65);
        ev("t1_f3",   EV_POS, 8'h04, 130);
        ev("t1_arr",  EV_ARR, 8'h14, 131);
        exp_door("t1", 131, 0, 4'b0100);
        ev("t1_idle", EV_UD,  8'h00, 154);
        wait_until(40);
        snap("t1_mid", {4'b0001, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0});
        drain("t1", 400);

        // T2: intermediate up stop, then continue up to the top
        do_reset("t2_reset");
        up_req = 4'b0010;
        in_req = 4'b1000;
        start();
        ev("t2_up",   EV_UD,  8'h01, 1);
        ev("t2_f2",   EV_POS, 8'h02, 65);
        ev("t2_arr2", EV_ARR, 8'h12, 66);
        exp_door("t2a", 66, 0, 4'b0010);
        ev("t2_f3",   EV_POS, 8'h04, 153);
        ev("t2_f4",   EV_POS, 8'h08, 218);
        ev("t2_arr4", EV_ARR, 8'h18, 219);
        exp_door("t2b", 219, 0, 4'b1000);
        ev("t2_idle", EV_UD,  8'h00, 242);
        wait_until(66);
        snap("t2_arr_snap", {4'b0010, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1});
        drain("t2", 400);

        // T3a: only a down call at the top; up sweep passes floors 2 and 3
        do_reset("t3_reset");
        down_req = 4'b1000;
        start();
        ev("t3_up",   EV_UD,  8'h01, 1);
        ev("t3_f2",   EV_POS, 8'h02, 65);
        ev("t3_f3",   EV_POS, 8'h04, 130);
        ev("t3_f4",   EV_POS, 8'h08, 195);
        ev("t3_arr",  EV_ARR, 8'h18, 196);
        exp_door("t3a", 196, 0, 4'b1000);
        ev("t3_idle", EV_UD,  8'h00, 219);
        drain("t3a", 400);

        // T3b: from the top, an up call at floor 2 is served on the down sweep (nothing below)
        up_req = 4'b0010;
        start();
        ev("t3b_dn",   EV_UD,  8'h02, 1);
        ev("t3b_f3",   EV_POS, 8'h04, 65);
        ev("t3b_f2",   EV_POS, 8'h02, 130);
        ev("t3b_arr",  EV_ARR, 8'h22, 131);
        exp_door("t3b", 131, 0, 4'b0010);
        ev("t3b_idle", EV_UD,  8'h00, 154);
        drain("t3b", 300);

        // T4a: door_close at count 5 jumps straight to count 18
        do_reset("t4_reset");
        in_req = 4'b0001;
        start();
        ev("t4a_arr",   EV_ARR,  8'h01, 1);
        ev("t4a_stg1",  EV_STG,  8'd1,  2);
        ev("t4a_stg2",  EV_STG,  8'd2,  3);
        ev("t4a_stg3",  EV_STG,  8'd3,  4);
        ev("t4a_stg2b", EV_STG,  8'd2,  8);
        ev("t4a_stg1b", EV_STG,  8'd1,  9);
        ev("t4a_stg0",  EV_STG,  8'd0,  10);
        ev("t4a_dend",  EV_DEND, 8'h01, 11);
        wait_until(6);
        door_close = 1'b1;
        wait_until(7);
        door_close = 1'b0;
        drain("t4a", 100);

        // T4b: hold (with close also asserted) for 10 ticks at count 10
        in_req = 4'b0001;
        start();
        ev("t4b_arr", EV_ARR, 8'h01, 1);
        exp_door("t4b", 1, 10, 4'b0001);
        wait_until(11);
        door_hold  = 1'b1;
        door_close = 1'b1;
        wait_until(21);
        door_hold  = 1'b0;
        door_close = 1'b0;
        drain("t4b", 100);

        // T5a: reset mid-move at travel count 30
        do_reset("t5_reset");
        in_req = 4'b1000;
        start();
        ev("t5_up",  EV_UD, 8'h01, 1);
        ev("t5_rst", EV_UD, 8'h00, 32);
        wait_until(31);
        rst    = 1'b1;
        in_req = 4'b0;
        wait_until(32);
        snap("t5_rst_snap", {4'b0001, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0});
        rst = 1'b0;
        drain("t5a", 50);

        // T5b: reset mid-door at count 8
        in_req = 4'b0001;
        start();
        ev("t5b_arr",  EV_ARR,  8'h01, 1);
        ev("t5b_stg1", EV_STG,  8'd1,  2);
        ev("t5b_stg2", EV_STG,  8'd2,  3);
        ev("t5b_stg3", EV_STG,  8'd3,  4);
        ev("t5b_stg0", EV_STG,  8'd0,  10);
        ev("t5b_dend", EV_DEND, 8'h01, 10);
        wait_until(9);
        rst = 1'b1;
        wait_until(10);
        snap("t5b_rst_snap", {4'b0001, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0});
        rst = 1'b0;
        drain("t5b", 50);

        // T6: park at floor 2, then simultaneous above and below calls -> up wins
        do_reset("t6_reset");
        in_req = 4'b0010;
        start();
        ev("t6_up",   EV_UD,  8'h01, 1);
        ev("t6_f2",   EV_POS, 8'h02, 65);
        ev("t6_arr",  EV_ARR, 8'h12, 66);
        exp_door("t6", 66, 0, 4'b0010);
        ev("t6_idle", EV_UD,  8'h00, 89);
        drain("t6a", 200);
        up_req = 4'b1000;
        in_req = 4'b0001;
        start();
        ev("t6_above_wins", EV_UD, 8'h01, 1);
        wait_until(2);
        snap("t6_snap", {4'b0010, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0});
        drain("t6b", 20);

        mute = 1'b1;
        step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
